// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_unit_pkg : opcode constants and immediate decode helpers   |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
package fetch_unit_pkg;

   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {
      PRED_NONE   = 2'd0,
      PRED_JAL    = 2'd1,
      PRED_BRANCH = 2'd2
   } pred_e;

   // Counters must hold 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic logic [31:0] imm_j(input logic [31:0] instr);
      return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
   endfunction

   function automatic logic [31:0] imm_b(input logic [31:0] instr);
      return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   endfunction

   // JAL always taken; conditional branches only when the offset is negative.
   function automatic pred_e classify(input logic [31:0] instr);
      if (instr[6:0] == OP_JAL)
         return PRED_JAL;
      if ((instr[6:0] == OP_BRANCH) && instr[31])
         return PRED_BRANCH;
      return PRED_NONE;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_unit_if : memory-side and decode-side fetch signals        |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
interface fetch_unit_if #(
   parameter int XLEN = 32
);
   logic            o_ifReq;
   logic [XLEN-1:0] o_ifAddr;
   logic            i_ifReady;
   logic            i_ifValid;
   logic [31:0]     i_instr;
   logic            o_valid;
   logic [31:0]     o_instr;
   logic [XLEN-1:0] o_pc;
   logic            o_predTaken;
   logic            i_ready;
   logic            i_redirect;
   logic [XLEN-1:0] i_redirectPc;

   modport master (
      output o_ifReq, o_ifAddr, o_valid, o_instr, o_pc, o_predTaken,
      input  i_ifReady, i_ifValid, i_instr, i_ready, i_redirect, i_redirectPc
   );

   modport slave (
      input  o_ifReq, o_ifAddr, o_valid, o_instr, o_pc, o_predTaken,
      output i_ifReady, i_ifValid, i_instr, i_ready, i_redirect, i_redirectPc
   );
endinterface
`default_nettype wire

// File: rtl/fetch_unit_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_fifo : synchronous FIFO with flush and occupancy count     |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module fetch_fifo
   import fetch_unit_pkg::*;
#(
   parameter int WIDTH = 65,
   parameter int DEPTH = 4
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic                        i_flush,
   input  logic                        i_push,
   input  logic [WIDTH-1:0]            i_data,
   input  logic                        i_pop,
   output logic                        o_valid,
   output logic [WIDTH-1:0]            o_data,
   output logic [cnt_width(DEPTH)-1:0] o_count,
   output logic                        o_full
);
   localparam int CW = cnt_width(DEPTH);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    rdPtr_q, rdPtr_d;
   logic [PW-1:0]    wrPtr_q, wrPtr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (cnt_q == CW'(DEPTH));
   assign o_valid = (cnt_q != '0);
   assign o_data  = mem_q[rdPtr_q];
   assign o_count = cnt_q;

   // Flush wins over any same-cycle push or pop.
   assign w_push = i_push && !o_full && !i_flush;
   assign w_pop  = i_pop && o_valid && !i_flush;

   always_comb begin
      rdPtr_d = rdPtr_q;
      wrPtr_d = wrPtr_q;
      cnt_d   = cnt_q;
      if (i_flush) begin
         rdPtr_d = '0;
         wrPtr_d = '0;
         cnt_d   = '0;
      end else begin
         if (w_push)
            wrPtr_d = wrPtr_q + PW'(1);
         if (w_pop)
            rdPtr_d = rdPtr_q + PW'(1);
         cnt_d = cnt_q + CW'(w_push) - CW'(w_pop);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rdPtr_q <= '0;
         wrPtr_q <= '0;
         cnt_q   <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= '0;
      end else begin
         rdPtr_q <= rdPtr_d;
         wrPtr_q <= wrPtr_d;
         cnt_q   <= cnt_d;
         if (w_push)
            mem_q[wrPtr_q] <= i_data;
      end
   end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_unit : prefetching RV32I fetch front end, static predict   |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter bit              PREDICT  = 1'b1
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   fetch_unit_if.master bus
);
   localparam int CW = cnt_width(DEPTH);
   localparam int EW = XLEN + 33;

   logic [XLEN-1:0] fetchPc_q, fetchPc_d;
   logic [XLEN-1:0] respPc_q, respPc_d;
   logic [CW-1:0]   outst_q, outst_d;
   logic [CW-1:0]   drop_q, drop_d;

   logic [CW-1:0]   w_count;
   logic            w_full;
   logic            w_valid;
   logic [EW-1:0]   w_headData;
   logic            w_resp;
   logic            w_keep;
   logic            w_push;
   logic            w_pop;
   logic            w_credit;
   logic            w_ifReq;
   logic            w_accept;
   logic            w_predRedirect;
   pred_e           w_kind;
   logic [31:0]     w_imm;
   logic [XLEN-1:0] w_target;
   logic [XLEN-1:0] w_redirectPc;

   // A response with nothing outstanding is a protocol violation and is ignored.
   assign w_resp = bus.i_ifValid && (outst_q != '0);
   assign w_keep = w_resp && (drop_q == '0) && !bus.i_redirect;

   assign w_kind         = PREDICT ? classify(bus.i_instr) : PRED_NONE;
   assign w_predRedirect = w_keep && (w_kind != PRED_NONE);
   assign w_imm          = (w_kind == PRED_JAL) ? imm_j(bus.i_instr) : imm_b(bus.i_instr);
   assign w_target       = respPc_q + XLEN'($signed(w_imm));
   assign w_redirectPc   = {bus.i_redirectPc[XLEN-1:2], 2'b00};

   // Credit uses the pre-pop count so the queue can never overflow.
   assign w_credit = ({1'b0, w_count} + {1'b0, outst_q}) < (CW+1)'(DEPTH);
   assign w_ifReq  = i_rst_n && !bus.i_redirect && !w_predRedirect && w_credit;
   assign w_accept = w_ifReq && bus.i_ifReady;

   assign w_push = w_keep && !w_full;
   assign w_pop  = w_valid && bus.i_ready;

   always_comb begin
      fetchPc_d = fetchPc_q;
      respPc_d  = respPc_q;
      outst_d   = outst_q + CW'(w_accept) - CW'(w_resp);
      drop_d    = drop_q;
      if (bus.i_redirect) begin
         // Everything still in flight belongs to the squashed path.
         fetchPc_d = w_redirectPc;
         respPc_d  = w_redirectPc;
         drop_d    = outst_q - CW'(w_resp);
      end else if (w_predRedirect) begin
         fetchPc_d = w_target;
         respPc_d  = w_target;
         drop_d    = outst_q - CW'(1);
      end else begin
         if (w_accept)
            fetchPc_d = fetchPc_q + XLEN'(4);
         if (w_keep)
            respPc_d = respPc_q + XLEN'(4);
         if (w_resp && (drop_q != '0))
            drop_d = drop_q - CW'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         fetchPc_q <= RESET_PC;
         respPc_q  <= RESET_PC;
         outst_q   <= '0;
         drop_q    <= '0;
      end else begin
         fetchPc_q <= fetchPc_d;
         respPc_q  <= respPc_d;
         outst_q   <= outst_d;
         drop_q    <= drop_d;
      end
   end

   fetch_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_flush (bus.i_redirect),
      .i_push  (w_push),
      .i_data  ({bus.i_instr, respPc_q, w_predRedirect}),
      .i_pop   (w_pop),
      .o_valid (w_valid),
      .o_data  (w_headData),
      .o_count (w_count),
      .o_full  (w_full)
   );

   assign bus.o_ifReq     = w_ifReq;
   assign bus.o_ifAddr    = fetchPc_q;
   assign bus.o_valid     = w_valid;
   assign bus.o_instr     = w_headData[EW-1 -: 32];
   assign bus.o_pc        = w_headData[XLEN:1];
   assign bus.o_predTaken = w_headData[0];

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fetch_unit : directed cycle-table bench for fetch_unit        |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_fetch_unit;
   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [31:0] JAL100 = 32'h1000_006F;  // jal x0, +0x100
   localparam logic [31:0] BEQ_BK = 32'hFE00_08E3;  // beq x0,x0,-16
   localparam logic [31:0] BEQ_FW = 32'h0000_0863;  // beq x0,x0,+16

   logic clk    = 1'b0;
   logic rst_n  = 1'b0;
   logic rst2_n = 1'b0;
   always #5 clk = ~clk;

   fetch_unit_if #(.XLEN(32)) bus ();
   fetch_unit_if #(.XLEN(32)) bus2 ();

   fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0), .PREDICT(1'b1)) dut (
      .i_clk (clk), .i_rst_n (rst_n), .bus (bus));

   fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0), .PREDICT(1'b0)) dut2 (
      .i_clk (clk), .i_rst_n (rst2_n), .bus (bus2));

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        rdy;
      logic        v;
      logic [31:0] ins;
      logic        rd;
      logic        redir;
      logic [31:0] rpc;
      logic        eReq;
      logic [31:0] eAddr;
      logic        eVal;
      logic [31:0] eIns;
      logic [31:0] ePc;
      logic        ePt;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic rdy, input logic v, input logic [31:0] ins,
                      input logic rd, input logic redir, input logic [31:0] rpc,
                      input logic eReq, input logic [31:0] eAddr, input logic eVal,
                      input logic [31:0] eIns, input logic [31:0] ePc, input logic ePt);
      vecs.push_back('{rdy, v, ins, rd, redir, rpc, eReq, eAddr, eVal, eIns, ePc, ePt});
   endtask

   always @(negedge clk) begin
      if (rst_n && dut.w_keep && dut.w_full) begin
         n_fail++;
         $display("FAIL overflow: push into full queue at %0t", $time);
      end
   end

   initial begin
      bus.i_ifReady = 1'b0;  bus.i_ifValid = 1'b0;  bus.i_instr = '0;
      bus.i_ready   = 1'b0;  bus.i_redirect = 1'b0; bus.i_redirectPc = '0;
      bus2.i_ifReady = 1'b0; bus2.i_ifValid = 1'b0; bus2.i_instr = '0;
      bus2.i_ready   = 1'b0; bus2.i_redirect = 1'b0; bus2.i_redirectPc = '0;

      //   rdy   v     ins     rd    redir rpc          req   addr          val   instr   pc            pt
      add(1'b1, 1'b0, NOP,    1'b0, 1'b0, 32'h0,       1'b1, 32'h000,      1'b0, NOP,    32'h0,        1'b0); // 0
      add(1'b1, 1'b0, NOP,    1'b0, 1'b0, 32'h0,       1'b1, 32'h004,      1'b0, NOP,    32'h0,        1'b0); // 1
      add(1'b1, 1'b1, NOP,    1'b0, 1'b0, 32'h0,       1'b1, 32'h008,      1'b0, NOP,    32'h0,        1'b0); // 2
      add(1'b1, 1'b1, NOP,    1'b1, 1'b0, 32'h0,       1'b1, 32'h00C,      1'b1, NOP,    32'h000,      1'b0); // 3
      add(1'b1, 1'b1, JAL100, 1'b1, 1'b0, 32'h0,       1'b0, 32'h010,      1'b1, NOP,    32'h004,      1'b0); // 4 JAL at 0x8
      add(1'b1, 1'b1, NOP,    1'b1, 1'b0, 32'h0,       1'b1, 32'h108,      1'b1, JAL100, 32'h008,      1'b1); // 5 0xC dropped
      add(1'b1, 1'b1, NOP,    1'b0, 1'b0, 32'h0,       1'b1, 32'h10C,      1'b0, NOP,    32'h0,        1'b0); // 6
      add(1'b1, 1'b1, NOP,    1'b0, 1'b0, 32'h0,       1'b1, 32'h110,      1'b1, NOP,    32'h108,      1'b0); // 7
      add(1'b1, 1'b1, NOP,    1'b0, 1'b0, 32'h0,       1'b1, 32'h114,      1'b1, NOP,    32'h108,      1'b0); // 8
      add(1'b1, 1'b1, NOP,    1'b0, 1'b0, 32'h0,       1'b0, 32'h118,      1'b1, NOP,    32'h108,      1'b0); // 9 credit exhausted
      add(1'b1, 1'b0, NOP,    1'b0, 1'b0, 32'h0,       1'b0, 32'h118,      1'b1, NOP,    32'h108,      1'b0); // 10
      add(1'b1, 1'b0, NOP,    1'b1, 1'b0, 32'h0,       1'b0, 32'h118,      1'b1, NOP,    32'h108,      1'b0); // 11 pre-pop credit
      add(1'b1, 1'b0, NOP,    1'b1, 1'b0, 32'h0,       1'b1, 32'h118,      1'b1, NOP,    32'h10C,      1'b0); // 12
      add(1'b1, 1'b0, NOP,    1'b1, 1'b1, 32'h400,     1'b0, 32'h11C,      1'b1, NOP,    32'h110,      1'b0); // 13 redirect
      add(1'b1, 1'b1, JAL100, 1'b1, 1'b0, 32'h0,       1'b1, 32'h400,      1'b0, NOP,    32'h0,        1'b0); // 14 stale JAL
      add(1'b1, 1'b1, BEQ_BK, 1'b1, 1'b0, 32'h0,       1'b0, 32'h404,      1'b0, NOP,    32'h0,        1'b0); // 15 backward BEQ
      add(1'b1, 1'b0, NOP,    1'b1, 1'b0, 32'h0,       1'b1, 32'h3F0,      1'b1, BEQ_BK, 32'h400,      1'b1); // 16
      add(1'b1, 1'b1, BEQ_FW, 1'b1, 1'b0, 32'h0,       1'b1, 32'h3F4,      1'b0, NOP,    32'h0,        1'b0); // 17 forward BEQ
      add(1'b1, 1'b0, NOP,    1'b1, 1'b0, 32'h0,       1'b1, 32'h3F8,      1'b1, BEQ_FW, 32'h3F0,      1'b0); // 18
      add(1'b1, 1'b1, JAL100, 1'b1, 1'b1, 32'h800,     1'b0, 32'h3FC,      1'b0, NOP,    32'h0,        1'b0); // 19 redirect beats JAL
      add(1'b1, 1'b1, NOP,    1'b1, 1'b0, 32'h0,       1'b1, 32'h800,      1'b0, NOP,    32'h0,        1'b0); // 20 stale dropped
      add(1'b1, 1'b1, NOP,    1'b1, 1'b0, 32'h0,       1'b1, 32'h804,      1'b0, NOP,    32'h0,        1'b0); // 21
      add(1'b0, 1'b0, NOP,    1'b1, 1'b0, 32'h0,       1'b1, 32'h808,      1'b1, NOP,    32'h800,      1'b0); // 22
      add(1'b0, 1'b1, NOP,    1'b0, 1'b0, 32'h0,       1'b1, 32'h808,      1'b0, NOP,    32'h0,        1'b0); // 23
      add(1'b0, 1'b1, JAL100, 1'b0, 1'b0, 32'h0,       1'b1, 32'h808,      1'b1, NOP,    32'h804,      1'b0); // 24 spurious resp
      add(1'b0, 1'b0, NOP,    1'b1, 1'b0, 32'h0,       1'b1, 32'h808,      1'b1, NOP,    32'h804,      1'b0); // 25
      add(1'b0, 1'b0, NOP,    1'b0, 1'b0, 32'h0,       1'b1, 32'h808,      1'b0, NOP,    32'h0,        1'b0); // 26

      repeat (2) @(negedge clk);
      #1;
      check("reset ifReq",     32'(bus.o_ifReq),     32'h0);
      check("reset valid",     32'(bus.o_valid),     32'h0);
      check("reset instr",     bus.o_instr,          32'h0);
      check("reset pc",        bus.o_pc,             32'h0);
      check("reset predTaken", 32'(bus.o_predTaken), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         bus.i_ifReady    = vecs[i].rdy;
         bus.i_ifValid    = vecs[i].v;
         bus.i_instr      = vecs[i].ins;
         bus.i_ready      = vecs[i].rd;
         bus.i_redirect   = vecs[i].redir;
         bus.i_redirectPc = vecs[i].rpc;
         #1;
         check($sformatf("row%0d ifReq", i),  32'(bus.o_ifReq), 32'(vecs[i].eReq));
         check($sformatf("row%0d ifAddr", i), bus.o_ifAddr,     vecs[i].eAddr);
         check($sformatf("row%0d valid", i),  32'(bus.o_valid), 32'(vecs[i].eVal));
         if (vecs[i].eVal) begin
            check($sformatf("row%0d instr", i), bus.o_instr,          vecs[i].eIns);
            check($sformatf("row%0d pc", i),    bus.o_pc,             vecs[i].ePc);
            check($sformatf("row%0d pred", i),  32'(bus.o_predTaken), 32'(vecs[i].ePt));
         end
      end

      // Mid-burst asynchronous reset.
      @(negedge clk);
      bus.i_ifReady = 1'b1; bus.i_ifValid = 1'b0; bus.i_ready = 1'b0;
      #1;
      check("burst ifAddr", bus.o_ifAddr, 32'h808);
      @(negedge clk);
      bus.i_ifReady = 1'b0; bus.i_ifValid = 1'b1; bus.i_instr = NOP;
      @(negedge clk);
      bus.i_ifValid = 1'b0;
      #1;
      check("burst valid", 32'(bus.o_valid), 32'h1);
      check("burst pc",    bus.o_pc,         32'h808);
      #2;
      rst_n = 1'b0;
      #1;
      check("async ifReq", 32'(bus.o_ifReq),     32'h0);
      check("async valid", 32'(bus.o_valid),     32'h0);
      check("async instr", bus.o_instr,          32'h0);
      check("async pc",    bus.o_pc,             32'h0);
      check("async pred",  32'(bus.o_predTaken), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rerelease ifReq",  32'(bus.o_ifReq), 32'h1);
      check("rerelease ifAddr", bus.o_ifAddr,     32'h0);
      check("rerelease valid",  32'(bus.o_valid), 32'h0);

      // PREDICT=0: backward BEQ and JAL both fetched sequentially.
      @(negedge clk);
      rst2_n = 1'b1;
      @(negedge clk);
      bus2.i_ifReady = 1'b1;
      #1;
      check("np c0 ifReq",  32'(bus2.o_ifReq), 32'h1);
      check("np c0 ifAddr", bus2.o_ifAddr,     32'h0);
      @(negedge clk);
      bus2.i_ifValid = 1'b1; bus2.i_instr = BEQ_BK;
      #1;
      check("np c1 ifReq",  32'(bus2.o_ifReq), 32'h1);
      check("np c1 ifAddr", bus2.o_ifAddr,     32'h4);
      @(negedge clk);
      bus2.i_instr = JAL100; bus2.i_ready = 1'b1;
      #1;
      check("np c2 ifAddr", bus2.o_ifAddr,          32'h8);
      check("np c2 valid",  32'(bus2.o_valid),      32'h1);
      check("np c2 instr",  bus2.o_instr,           BEQ_BK);
      check("np c2 pc",     bus2.o_pc,              32'h0);
      check("np c2 pred",   32'(bus2.o_predTaken),  32'h0);
      @(negedge clk);
      bus2.i_ifValid = 1'b0; bus2.i_ifReady = 1'b0;
      #1;
      check("np c3 ifAddr", bus2.o_ifAddr,          32'hC);
      check("np c3 instr",  bus2.o_instr,           JAL100);
      check("np c3 pc",     bus2.o_pc,              32'h4);
      check("np c3 pred",   32'(bus2.o_predTaken),  32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
